fip_addsub_pipe: RTL and testbench
==================================

Name: fip_addsub_pipe

Overview:
Parametrised, pipelined signed fixed-point add/subtract unit. It is the successor to the combinational 32-bit Q16.16 adder and subtractor, and serves the ray/box intersection datapath. It adds a runtime op select, per-transaction saturate-or-wrap mode, valid/ready flow control with full backpressure, and a sticky overflow flag with a saturating event counter.

Parameters:
WIDTH, 32, total operand/result width in bits (two's complement)
FRAC, 16, fractional bits (format Q(WIDTH-FRAC).FRAC; only documents the format, arithmetic is identical)
CNT_W, 16, width of overflow event counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  unit can accept input this cycle
x  in  WIDTH  operand x, signed
y  in  WIDTH  operand y, signed
op  in  1  0 = x+y, 1 = x-y
sat  in  1  1 = saturate on overflow, 0 = wrap
out_valid  out  1  result valid
out_ready  in  1  downstream accepts result
result  out  WIDTH  signed result
overflow  out  1  overflow occurred for this result (qualified by out_valid)
ovf_sticky  out  1  set by any delivered overflow; cleared by clr_ovf
ovf_count  out  CNT_W  delivered-overflow count, saturates at all-ones
clr_ovf  in  1  synchronous clear of ovf_sticky/ovf_count

Behaviour:
- Reset is asynchronous and active-high. One clock domain, clk.
- Reset values: in_ready=0 while reset is asserted, 1 from the first cycle after release. out_valid=0, result=0, overflow=0, ovf_sticky=0, ovf_count=0.
- Two-stage pipeline; latency is exactly 2 cycles from accept (in_valid&&in_ready) to out_valid with no stall. Throughput is 1 per cycle.
- S1: registers a (WIDTH+1)-bit raw value: sign-extended x plus sign-extended y (op=0), or minus sign-extended y (op=1). Also registers sat.
- S2: ovf = raw[WIDTH] != raw[WIDTH-1]. If ovf=0, result = raw[WIDTH-1:0].
- S2 overflow, sat=0: result = raw[WIDTH-1:0] (wrap).
- S2 overflow, sat=1: result = 0111..1 if raw[WIDTH]=0, or 1000..0 if raw[WIDTH]=1.
- The overflow output is registered alongside result.
- Flow control:
  - adv2 = !s2_valid || out_ready
  - adv1 = !s1_valid || adv2
  - in_ready = adv1
  - There is a combinational path out_ready->in_ready, which is accepted.
- A stalled stage holds data, op, sat and overflow stable. With out_valid=1 && out_ready=0, outputs must not change.
- Order is preserved and there is no drop or duplication. Maximum in-flight count is 2.
- in_valid with in_ready=0 is not accepted; the source must hold.
- Overflow accounting happens on a delivered transfer (out_valid&&out_ready&&overflow), at most one event per cycle.
  - ovf_sticky is set to 1.
  - ovf_count increments, holding at 2^CNT_W-1.
- clr_ovf with no event: sticky=0, count=0.
- clr_ovf in the same cycle as an event: the event wins, so sticky=1 and count=1.
- Reset mid-operation: all in-flight transactions are discarded and out_valid drops immediately (asynchronously). No partial result is emitted after release.
- The most-negative input is legal. Example: 0 - 1000..0 overflows, giving a wrap to 1000..0 or a saturate to 0111..1.

Decomposition:
- Package fip_pkg holds:
  - op encodings OP_ADD=1'b0, OP_SUB=1'b1
  - functions fip_max(WIDTH) / fip_min(WIDTH) returning the saturation constants
  - a typedef for the S1 payload struct (raw, sat)
- One sub-module, fip_sat_wrap: combinational. Takes the (WIDTH+1)-bit raw value and sat; produces result and ovf. Used in S2.
- Pipeline registers and handshake live in the top module.

Test Plan:
1. WIDTH=32, op=0, x=0x00010000, y=0x00020000, out_ready=1 -> 2 cycles after accept: result=0x00030000, overflow=0. Then x=0xFFFF0000, y=0xFFFFFFFF -> result=0xFFFEFFFF, overflow=0.
2. op=0, x=0x7FFFFFFF, y=0x00010000: sat=0 -> result=0x8000FFFF, overflow=1; sat=1 -> result=0x7FFFFFFF, overflow=1. Check ovf_sticky=1 and ovf_count=2 after both are delivered.
3. op=1, x=0x80000000, y=1: sat=0 -> result=0x7FFFFFFF, overflow=1; sat=1 -> 0x80000000. op=1, x=0, y=0x80000000, sat=1 -> result=0x7FFFFFFF.
4. Backpressure: drive 4 back-to-back inputs (1,2,3,4 in Q16.16 added to 0) with out_ready=0 -> in_ready drops after 2 accepts and result is held stable. Raise out_ready -> outputs 1,2,3,4 in order on consecutive cycles, no gaps or duplicates.
5. CNT_W=2: deliver 5 overflows -> ovf_count=3 (saturated). Assert clr_ovf in the same cycle as a 6th delivered overflow -> ovf_count=1, ovf_sticky=1. Next cycle clr_ovf alone -> 0 and 0.
6. Two transactions in flight, assert reset for 1 cycle mid-stream -> out_valid=0 at once, no result emerges afterwards. in_ready=1 one cycle after release, and a new 1.0+1.0 returns 0x00020000 after 2 cycles.

Source files
------------

// File: rtl/fip_pkg.sv
// Shared definitions for the pipelined fixed-point add/subtract unit:
// opcode encodings, saturation constants and the stage-1 payload type.
package fip_pkg;

    // Widest datapath the shared payload type can carry.
    localparam int FIP_WMAX = 64;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // The raw sum is kept sign-extended to the full carrier width; the top
    // only consumes bits [WIDTH:0].
    typedef struct packed {
        logic [FIP_WMAX:0] raw;
        logic              sat;
    } fip_s1_t;

    function automatic logic [FIP_WMAX-1:0] fip_max(input int width);
        logic [FIP_WMAX-1:0] v;
        v = '0;
        for (int i = 0; i < FIP_WMAX; i++) begin
            v[i] = (i < width - 1) ? 1'b1 : 1'b0;
        end
        return v;
    endfunction

    function automatic logic [FIP_WMAX-1:0] fip_min(input int width);
        logic [FIP_WMAX-1:0] v;
        v = '0;
        for (int i = 0; i < FIP_WMAX; i++) begin
            v[i] = (i == width - 1) ? 1'b1 : 1'b0;
        end
        return v;
    endfunction

endpackage

// File: rtl/fip_sat_wrap.sv
// Overflow detection and saturate-or-wrap selection on a (WIDTH+1)-bit
// raw sum. Purely combinational; sits in front of the output registers.
module fip_sat_wrap
    import fip_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   raw,
    input  logic             sat,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);

    localparam logic [FIP_WMAX-1:0] MAX_FULL = fip_max(WIDTH);
    localparam logic [FIP_WMAX-1:0] MIN_FULL = fip_min(WIDTH);
    localparam logic [WIDTH-1:0]    SAT_MAX  = MAX_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0]    SAT_MIN  = MIN_FULL[WIDTH-1:0];

    // The guard bit disagreeing with the sign bit means the sum left range.
    always_comb begin
        ovf    = raw[WIDTH] ^ raw[WIDTH-1];
        result = raw[WIDTH-1:0];
        if (ovf && sat) begin
            if (raw[WIDTH]) begin
                result = SAT_MIN;
            end else begin
                result = SAT_MAX;
            end
        end else begin
            result = raw[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fip_addsub_pipe.sv
// Two-stage signed fixed-point add/subtract with valid/ready backpressure,
// per-transaction saturate/wrap and delivered-overflow accounting.
module fip_addsub_pipe
    import fip_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int FRAC  = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             op,
    input  logic             sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_ovf
);

    // FRAC only names the number format; the arithmetic is format-agnostic.
    localparam int unused_int_bits = WIDTH - FRAC;

    logic             ready_en_q, ready_en_d;
    logic             s1_valid_q, s1_valid_d;
    fip_s1_t          s1_q, s1_d;
    logic             s2_valid_q, s2_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             overflow_q, overflow_d;
    logic             ovf_sticky_q, ovf_sticky_d;
    logic [CNT_W-1:0] ovf_count_q, ovf_count_d;

    logic             adv1_s, adv2_s, accept_s, ovf_event_s;
    logic [WIDTH:0]   xe_s, ye_s, sum_s, raw2_s;
    logic [WIDTH-1:0] sw_result_s;
    logic             sw_ovf_s;

    // Handshake: a stage moves when it is empty or its successor moves.
    always_comb begin
        adv2_s     = !s2_valid_q || out_ready;
        adv1_s     = !s1_valid_q || adv2_s;
        in_ready   = ready_en_q && adv1_s;
        accept_s   = in_valid && in_ready;
        ready_en_d = 1'b1;
    end

    // Stage 1: exact (WIDTH+1)-bit sum or difference of sign-extended operands.
    always_comb begin
        xe_s       = {x[WIDTH-1], x};
        ye_s       = {y[WIDTH-1], y};
        case (op)
            OP_ADD:  sum_s = xe_s + ye_s;
            OP_SUB:  sum_s = xe_s - ye_s;
            default: sum_s = xe_s + ye_s;
        endcase
        s1_valid_d = s1_valid_q;
        s1_d       = s1_q;
        if (adv1_s) begin
            s1_valid_d = accept_s;
            if (accept_s) begin
                s1_d.raw = (FIP_WMAX + 1)'(signed'(sum_s));
                s1_d.sat = sat;
            end else begin
                s1_d = s1_q;
            end
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    assign raw2_s = s1_q.raw[WIDTH:0];

    generate
        if (WIDTH < FIP_WMAX) begin : g_raw_hi
            logic unused_raw_hi_s;
            assign unused_raw_hi_s = ^s1_q.raw[FIP_WMAX:WIDTH+1];
        end
    endgenerate

    fip_sat_wrap #(
        .WIDTH (WIDTH)
    ) u_sat_wrap (
        .raw    (raw2_s),
        .sat    (s1_q.sat),
        .result (sw_result_s),
        .ovf    (sw_ovf_s)
    );

    // Stage 2: result and its overflow flag are captured together.
    always_comb begin
        s2_valid_d = s2_valid_q;
        result_d   = result_q;
        overflow_d = overflow_q;
        if (adv2_s) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                result_d   = sw_result_s;
                overflow_d = sw_ovf_s;
            end else begin
                result_d   = result_q;
                overflow_d = overflow_q;
            end
        end else begin
            s2_valid_d = s2_valid_q;
        end
    end

    // Accounting only on delivered results; an event beats a same-cycle clear.
    always_comb begin
        ovf_event_s  = s2_valid_q && out_ready && overflow_q;
        ovf_sticky_d = ovf_sticky_q;
        ovf_count_d  = ovf_count_q;
        if (ovf_event_s) begin
            ovf_sticky_d = 1'b1;
            if (clr_ovf) begin
                ovf_count_d = CNT_W'(1);
            end else if (ovf_count_q == {CNT_W{1'b1}}) begin
                ovf_count_d = ovf_count_q;
            end else begin
                ovf_count_d = ovf_count_q + CNT_W'(1);
            end
        end else if (clr_ovf) begin
            ovf_sticky_d = 1'b0;
            ovf_count_d  = '0;
        end else begin
            ovf_sticky_d = ovf_sticky_q;
            ovf_count_d  = ovf_count_q;
        end
    end

    // State registers; reset discards everything in flight immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en_q   <= 1'b0;
            s1_valid_q   <= 1'b0;
            s1_q         <= '0;
            s2_valid_q   <= 1'b0;
            result_q     <= '0;
            overflow_q   <= 1'b0;
            ovf_sticky_q <= 1'b0;
            ovf_count_q  <= '0;
        end else begin
            ready_en_q   <= ready_en_d;
            s1_valid_q   <= s1_valid_d;
            s1_q         <= s1_d;
            s2_valid_q   <= s2_valid_d;
            result_q     <= result_d;
            overflow_q   <= overflow_d;
            ovf_sticky_q <= ovf_sticky_d;
            ovf_count_q  <= ovf_count_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign result     = result_q;
    assign overflow   = overflow_q;
    assign ovf_sticky = ovf_sticky_q;
    assign ovf_count  = ovf_count_q;

endmodule

// File: tb/tb_fip_addsub_pipe.sv
// Scoreboard bench: the driver pushes reference results on accept, an
// independent monitor pops and compares on every delivered transfer.
module tb_fip_addsub_pipe;

    localparam int TB_CNT_W = 2;
    localparam int CNT_MAX  = (1 << TB_CNT_W) - 1;

    logic                clk = 1'b0;
    logic                reset;
    logic                in_valid, in_ready;
    logic [31:0]         x, y, result;
    logic                op, sat;
    logic                out_valid, out_ready;
    logic                overflow, ovf_sticky, clr_ovf;
    logic [TB_CNT_W-1:0] ovf_count;

    int          checks = 0;
    int          errors = 0;
    int          n_accepted = 0;
    logic [32:0] sb_q[$];

    fip_addsub_pipe #(
        .WIDTH (32),
        .FRAC  (16),
        .CNT_W (TB_CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .x          (x),
        .y          (y),
        .op         (op),
        .sat        (sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .overflow   (overflow),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .clr_ovf    (clr_ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, then range check against Q16.16 limits.
    function automatic logic [32:0] model(input logic [31:0] xi, input logic [31:0] yi,
                                          input logic opi, input logic sati);
        longint      sx, sy, r;
        logic [63:0] rr;
        logic        ovf;
        logic [31:0] res;
        sx  = longint'($signed(xi));
        sy  = longint'($signed(yi));
        r   = opi ? (sx - sy) : (sx + sy);
        rr  = r;
        ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
        if (ovf && sati) res = (r > 64'sd0) ? 32'h7FFFFFFF : 32'h80000000;
        else             res = rr[31:0];
        return {ovf, res};
    endfunction

    task automatic send(input logic [31:0] xi, input logic [31:0] yi,
                        input logic opi, input logic sati);
        int waited;
        waited   = 0;
        in_valid = 1'b1;
        x = xi; y = yi; op = opi; sat = sati;
        forever begin
            @(negedge clk);
            if (in_ready) begin
                sb_q.push_back(model(xi, yi, opi, sati));
                n_accepted++;
                @(posedge clk); #1;
                break;
            end
            waited++;
            if (waited > 60) begin
                chk("send_timeout", 64'd1, 64'd0);
                @(posedge clk); #1;
                break;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_timeout", (n >= 100) ? 64'd1 : 64'd0, 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'h7FFFFFFF;
            1:       return 32'h80000000;
            2:       return 32'h00000000;
            3:       return 32'hFFFFFFFF;
            default: return $urandom();
        endcase
    endfunction

    // Monitor: compares deliveries, holds during stalls and the overflow counters.
    initial begin
        logic [32:0] exp_v;
        logic        stalled, ev, m_sticky;
        logic [31:0] prev_res;
        logic        prev_ovf;
        int          m_cnt;
        stalled = 1'b0; m_sticky = 1'b0; m_cnt = 0; prev_res = '0; prev_ovf = 1'b0;
        forever begin
            @(negedge clk);
            if (reset) begin
                sb_q.delete();
                m_cnt = 0; m_sticky = 1'b0; stalled = 1'b0;
                chk("rst_out_valid", out_valid, 64'd0);
                chk("rst_in_ready", in_ready, 64'd0);
                continue;
            end
            chk("ovf_count", ovf_count, m_cnt);
            chk("ovf_sticky", ovf_sticky, m_sticky);
            if (stalled && out_valid) begin
                chk("stall_hold_result", result, prev_res);
                chk("stall_hold_ovf", overflow, prev_ovf);
            end
            ev = 1'b0;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    chk("unexpected_output", 64'd1, 64'd0);
                end else begin
                    exp_v = sb_q.pop_front();
                    chk("result", result, exp_v[31:0]);
                    chk("overflow", overflow, exp_v[32]);
                    ev = exp_v[32];
                end
            end
            if (ev) begin
                m_sticky = 1'b1;
                m_cnt    = clr_ovf ? 1 : ((m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX);
            end else if (clr_ovf) begin
                m_sticky = 1'b0;
                m_cnt    = 0;
            end
            stalled  = out_valid && !out_ready;
            prev_res = result;
            prev_ovf = overflow;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1);
    end

    initial begin
        int seen;
        bit done;
        reset = 1'b1; in_valid = 1'b0; x = '0; y = '0; op = 1'b0; sat = 1'b0;
        out_ready = 1'b1; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_result", result, 64'd0);
        chk("reset_overflow", overflow, 64'd0);
        chk("reset_sticky", ovf_sticky, 64'd0);
        chk("reset_count", ovf_count, 64'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_release", in_ready, 64'd1);

        // Basic adds and two-cycle latency.
        send(32'h00010000, 32'h00020000, 1'b0, 1'b0);
        chk("lat_cycle1", out_valid, 64'd0);
        @(posedge clk); #1;
        chk("lat_cycle2", out_valid, 64'd1);
        chk("t1a_result", result, 64'h00030000);
        send(32'hFFFF0000, 32'hFFFFFFFF, 1'b0, 1'b0);
        drain();

        // Positive overflow, wrap then saturate.
        send(32'h7FFFFFFF, 32'h00010000, 1'b0, 1'b0);
        send(32'h7FFFFFFF, 32'h00010000, 1'b0, 1'b1);
        drain();
        chk("t2_sticky", ovf_sticky, 64'd1);
        chk("t2_count", ovf_count, 64'd2);

        // Subtraction at the most-negative boundary.
        send(32'h80000000, 32'h00000001, 1'b1, 1'b0);
        send(32'h80000000, 32'h00000001, 1'b1, 1'b1);
        send(32'h00000000, 32'h80000000, 1'b1, 1'b1);
        drain();

        // Backpressure: two accepts then stall, release gives four in a row.
        out_ready = 1'b0; n_accepted = 0;
        fork
            begin
                for (int i = 1; i <= 4; i++) send(32'(i) << 16, 32'h0, 1'b0, 1'b0);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                chk("bp_accepts", n_accepted, 64'd2);
                chk("bp_in_ready", in_ready, 64'd0);
                chk("bp_out_valid", out_valid, 64'd1);
                chk("bp_hold_result", result, 64'h00010000);
                out_ready = 1'b1;
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    chk("bp_no_gap", out_valid, 64'd1);
                end
            end
        join
        drain();

        // Counter saturation and clear/event priority.
        clr_ovf = 1'b1;
        @(posedge clk); #1;
        clr_ovf = 1'b0;
        chk("t5_clear", ovf_count, 64'd0);
        for (int i = 0; i < 5; i++) send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0);
        drain();
        chk("t5_saturated", ovf_count, 64'd3);
        out_ready = 1'b0;
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b1);
        @(posedge clk); #1;
        chk("t5_pending", out_valid, 64'd1);
        out_ready = 1'b1; clr_ovf = 1'b1;
        @(posedge clk); #1;
        chk("t5_event_wins_cnt", ovf_count, 64'd1);
        chk("t5_event_wins_sticky", ovf_sticky, 64'd1);
        @(posedge clk); #1;
        chk("t5_clr_cnt", ovf_count, 64'd0);
        chk("t5_clr_sticky", ovf_sticky, 64'd0);
        clr_ovf = 1'b0;

        // Reset with two transactions in flight.
        out_ready = 1'b0;
        send(32'h00050000, 32'h00010000, 1'b0, 1'b0);
        send(32'h00060000, 32'h00010000, 1'b0, 1'b0);
        reset = 1'b1;
        #1;
        chk("rst_async_drop", out_valid, 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        chk("rst_release_ready", in_ready, 64'd0);
        @(posedge clk); #1;
        chk("rst_ready_next", in_ready, 64'd1);
        out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("rst_no_residue", seen, 64'd0);
        @(posedge clk); #1;
        send(32'h00010000, 32'h00010000, 1'b0, 1'b0);
        chk("rst_new_lat1", out_valid, 64'd0);
        @(posedge clk); #1;
        chk("rst_new_lat2", out_valid, 64'd1);
        chk("rst_new_result", result, 64'h00020000);
        drain();

        // Random traffic with random backpressure and clears.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 300; i++) begin
                    send(pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                    clr_ovf   = ($urandom_range(0, 15) == 0);
                end
            end
        join
        out_ready = 1'b1; clr_ovf = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
